// File: rtl/simple_bus_mem_responder.sv
// Responder end of the simple_bus req/gnt/start/rdy handshake with a byte-wide register-file memory.
// Optional SB_RESP_VIOLATION_CNT_EN adds viol_cnt, counting ignored starts and illegal responses.
module simple_bus_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       gnt,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [1:0] mode,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       err
`ifdef SB_RESP_VIOLATION_CNT_EN
    ,
    output logic [7:0] viol_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RESP} state_t;

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MEM_WORDS = 1 << AW;
    localparam logic [8:0]  DEPTH_LIM = 9'(DEPTH);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [7:0] addr_q, wdata_q;
    logic [1:0] mode_q;
    logic       capture, finish, illegal, mem_we;
    logic [7:0] old_byte, resp_data, mem_wdata;
    logic [7:0] mem [0:MEM_WORDS-1];

    assign gnt = (state != IDLE);
    assign rdy = (state == RESP);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_next = GRANTED;
            end
            GRANTED: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = 4'(WAIT_STATES);
                    capture    = 1'b1;
                end else if (!req) begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = RESP;
                    finish     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = req ? GRANTED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and memory update are both resolved on the edge leaving BUSY.
    always_comb begin
        illegal   = (mode_q == 2'b11) || ({1'b0, addr_q} >= DEPTH_LIM);
        old_byte  = mem[addr_q[AW-1:0]];
        resp_data = '0;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        if (!illegal) begin
            case (mode_q)
                2'b00: resp_data = old_byte;
                2'b01: begin
                    resp_data = wdata_q;
                    mem_we    = finish;
                end
                2'b10: begin
                    resp_data = old_byte;
                    mem_wdata = old_byte + 8'd1;
                    mem_we    = finish;
                end
                default: resp_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            mode_q   <= '0;
            wdata_q  <= '0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                addr_q  <= addr;
                mode_q  <= mode;
                wdata_q <= data_in;
            end
            if (finish) begin
                data_out <= resp_data;
                err      <= illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[AW-1:0]] <= mem_wdata;
    end

`ifdef SB_RESP_VIOLATION_CNT_EN
    logic [1:0] viol_inc;
    logic [8:0] viol_sum;

    always_comb begin
        viol_inc = 2'(start && (state != GRANTED)) + 2'((state == RESP) && err);
        viol_sum = {1'b0, viol_cnt} + 9'(viol_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) viol_cnt <= '0;
        else     viol_cnt <= viol_sum[8] ? 8'hFF : viol_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_simple_bus_mem_responder.sv
// Scoreboard bench for simple_bus_mem_responder: driver pushes expected responses from a
// behavioural memory model, an independent monitor checks every rdy pulse.
module tb_simple_bus_mem_responder;

    localparam int DEPTH = 16;
    localparam int WS    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       start = 1'b0;
    logic [7:0] addr = '0;
    logic [1:0] mode = '0;
    logic [7:0] data_in = '0;
    logic       gnt, rdy, err;
    logic [7:0] data_out;
`ifdef SB_RESP_VIOLATION_CNT_EN
    logic [7:0] viol_cnt;
`endif

    simple_bus_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .start(start),
        .addr(addr),
        .mode(mode),
        .data_in(data_in),
        .data_out(data_out),
        .rdy(rdy),
        .err(err)
`ifdef SB_RESP_VIOLATION_CNT_EN
        ,
        .viol_cnt(viol_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [0:255];
    int         checks = 0;
    int         errors = 0;
    int         exp_viol = 0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic add_viol(input int n);
        exp_viol = (exp_viol + n > 255) ? 255 : exp_viol + n;
    endtask

    task automatic chk_viol();
`ifdef SB_RESP_VIOLATION_CNT_EN
        chk8("viol_cnt", viol_cnt, 8'(exp_viol));
`endif
    endtask

    // Monitor: every rdy must match the oldest expectation, in the predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_rdy: got none expected rdy at cycle %0d", sb[0].due);
                void'(sb.pop_front());
            end
            if (rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: got rdy at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL rdy_latency: got cycle %0d expected cycle %0d", cyc, e.due);
                    end
                    chk8("data_out", data_out, e.data);
                    chk1("err", err, e.err);
                end
            end
        end
    end

    // Called at a negedge while granted; returns at the first negedge where a new start may be issued.
    task automatic do_txn(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d,
                          input bit drop, input bit stray);
        exp_t       e;
        logic [7:0] exp_d;
        logic       exp_e;
        exp_e = (m == 2'b11) || (int'(a) >= DEPTH);
        exp_d = 8'h00;
        if (!exp_e) begin
            case (m)
                2'b00: exp_d = model[a];
                2'b01: begin exp_d = d; model[a] = d; end
                2'b10: begin exp_d = model[a]; model[a] = model[a] + 8'd1; end
                default: exp_d = 8'h00;
            endcase
        end
        e.data = exp_d;
        e.err  = exp_e;
        e.due  = cyc + 2 + WS;
        sb.push_back(e);
        start = 1'b1; addr = a; mode = m; data_in = d;
        @(negedge clk);
        start = 1'b0; addr = 8'($urandom); mode = 2'($urandom); data_in = 8'($urandom);
        if (drop) req = 1'b0;
        if (stray) start = 1'b1;
        repeat (WS + 1) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk1("gnt_hold", gnt, 1'b1);
        if (stray) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("gnt_after", gnt, drop ? 1'b0 : 1'b1);
        add_viol((stray ? 2 : 0) + (exp_e ? 1 : 0));
        chk_viol();
    endtask

    task automatic acquire();
        req = 1'b1;
        @(negedge clk);
        chk1("gnt_rise", gnt, 1'b1);
    endtask

    initial begin
        int rdy_seen;
        repeat (3) @(negedge clk);
        chk1("rst_gnt", gnt, 1'b0);
        chk1("rst_rdy", rdy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk8("rst_data", data_out, 8'h00);
        chk_viol();
        rst = 1'b0;

        // start while req is just rising, before gnt: must be ignored
        req = 1'b1; start = 1'b1; addr = 8'h04; mode = 2'b01; data_in = 8'hEE;
        chk1("gnt_latency", gnt, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk1("gnt_rise", gnt, 1'b1);
        add_viol(1);

        for (int i = 0; i < DEPTH; i++) do_txn(2'b01, 8'(i), 8'($urandom), 1'b0, 1'b0);

        do_txn(2'b01, 8'h0A, 8'hA5, 1'b0, 1'b0);
        do_txn(2'b00, 8'h0A, 8'h00, 1'b0, 1'b0);
        do_txn(2'b01, 8'h02, 8'hFF, 1'b0, 1'b0);
        do_txn(2'b10, 8'h02, 8'h00, 1'b0, 1'b0);
        do_txn(2'b00, 8'h02, 8'h00, 1'b0, 1'b0);
        do_txn(2'b00, 8'h10, 8'h00, 1'b0, 1'b0);
        do_txn(2'b11, 8'h03, 8'h77, 1'b0, 1'b0);
        do_txn(2'b00, 8'h03, 8'h00, 1'b0, 1'b0);
        do_txn(2'b00, 8'h05, 8'h00, 1'b1, 1'b0);
        acquire();
        do_txn(2'b11, 8'hF0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            bit drop;
            drop = ($urandom_range(0, 5) == 0);
            do_txn(2'($urandom_range(0, 3)), 8'($urandom_range(0, 19)), 8'($urandom),
                   drop, ($urandom_range(0, 3) == 0));
            if (drop) acquire();
        end

        // Reset during BUSY discards a pending write
        do_txn(2'b01, 8'h01, 8'h11, 1'b0, 1'b0);
        start = 1'b1; addr = 8'h01; mode = 2'b01; data_in = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("midrst_gnt", gnt, 1'b0);
        chk1("midrst_rdy", rdy, 1'b0);
        chk1("midrst_err", err, 1'b0);
        chk8("midrst_data", data_out, 8'h00);
        exp_viol = 0;
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_viol();
        rdy_seen = 0;
        repeat (WS + 4) begin
            @(negedge clk);
            if (rdy === 1'b1) rdy_seen++;
        end
        checks++;
        if (rdy_seen != 0) begin
            errors++;
            $display("FAIL midrst_no_rdy: got %0d rdy pulses expected 0", rdy_seen);
        end
        acquire();
        do_txn(2'b00, 8'h01, 8'h00, 1'b1, 1'b0);

        // Stray starts while idle
        start = 1'b1;
        repeat (300) @(negedge clk);
        start = 1'b0;
        add_viol(300);
        @(negedge clk);
        chk_viol();
        chk1("idle_gnt", gnt, 1'b0);

        repeat (WS + 4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
